// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: access-mode codes,
// FSM state type and mode decode helpers.
package dmem_pkg;

    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT2 = 2'd1,
        ST_RESP  = 2'd2
    } dmem_state_e;

    // Access size in bytes; 0 marks an illegal mode code.
    function automatic logic [2:0] mode_bytes(input logic [2:0] mode);
        case (mode)
            MODE_B, MODE_BU: mode_bytes = 3'd1;
            MODE_H, MODE_HU: mode_bytes = 3'd2;
            MODE_W:          mode_bytes = 3'd4;
            default:         mode_bytes = 3'd0;
        endcase
    endfunction

    function automatic logic mode_legal(input logic [2:0] mode);
        return (mode_bytes(mode) != 3'd0);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-wide single-port RAM with per-byte write enables and a registered
// read port, written so that it maps onto block RAM.
module dmem_ram #(
    parameter int AW        = 10,
    parameter int INIT_ZERO = 1
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    localparam int          DEPTH     = 1 << AW;
    localparam logic [31:0] INIT_WORD = (INIT_ZERO != 0) ? 32'h0000_0000 : 32'hxxxx_xxxx;

    logic [31:0] mem_r [DEPTH] = '{default: INIT_WORD};

    // Read-before-write port: the addressed word is registered on every enabled edge.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem_r[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
            rdata <= mem_r[addr];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressed little-endian data memory with valid/ready request and
// response channels; word-crossing accesses are serviced in two beats.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int MISALIGN_EN = 1,
    parameter int INIT_ZERO   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_mode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int WA_W = ADDR_W - 2;
    localparam int AW1  = ADDR_W + 1;

    dmem_state_e     state_r;
    logic [2:0]      mode_r;
    logic [1:0]      lane_r;
    logic            we_r;
    logic            err_r;
    logic            split_r;
    logic [3:0]      be1_r;
    logic [31:0]     wd1_r;
    logic [31:0]     lo_r;
    logic [WA_W-1:0] idx1_r;

    logic            acc_s;
    logic [2:0]      size_s;
    logic [1:0]      lane_s;
    logic [WA_W-1:0] idx_s;
    logic [AW1-1:0]  end_s;
    logic            misal_s;
    logic            cross_s;
    logic            err_s;
    logic [3:0]      mask4_s;
    logic [7:0]      mask8_s;
    logic [63:0]     wide_s;

    logic            ram_en_s;
    logic [3:0]      ram_we_s;
    logic [WA_W-1:0] ram_addr_s;
    logic [31:0]     ram_wdata_s;
    logic [31:0]     ram_rdata_s;

    logic [63:0]     merged_s;
    logic [31:0]     sel_s;
    logic [31:0]     ext_s;

    assign req_ready = (state_r == ST_IDLE) || ((state_r == ST_RESP) && rsp_ready);
    assign acc_s     = req_valid && req_ready;

    // Request decode: legality, word crossing, and lane placement of both beats.
    always_comb begin
        size_s  = mode_bytes(req_mode);
        lane_s  = req_addr[1:0];
        idx_s   = req_addr[ADDR_W-1:2];
        // One extra bit so an access running past the top is caught, not wrapped.
        end_s   = {1'b0, req_addr} + AW1'(size_s) - AW1'(1'b1);
        misal_s = ((size_s == 3'd2) && req_addr[0]) || ((size_s == 3'd4) && (lane_s != 2'd0));
        cross_s = (({1'b0, lane_s} + size_s) > 3'd4);
        err_s   = !mode_legal(req_mode) || end_s[ADDR_W] || (misal_s && (MISALIGN_EN == 0));
        case (size_s)
            3'd1:    mask4_s = 4'b0001;
            3'd2:    mask4_s = 4'b0011;
            3'd4:    mask4_s = 4'b1111;
            default: mask4_s = 4'b0000;
        endcase
        mask8_s = {4'b0000, mask4_s} << lane_s;
        wide_s  = {32'h0000_0000, req_wdata} << {lane_s, 3'b000};
    end

    // RAM port steering: beat 1 of a split access, else beat 0 of a fresh legal request.
    always_comb begin
        ram_en_s    = 1'b0;
        ram_we_s    = 4'b0000;
        ram_addr_s  = idx_s;
        ram_wdata_s = wide_s[31:0];
        if (state_r == ST_BEAT2) begin
            ram_en_s    = 1'b1;
            ram_we_s    = we_r ? be1_r : 4'b0000;
            ram_addr_s  = idx1_r;
            ram_wdata_s = wd1_r;
        end else if (acc_s && !err_s) begin
            ram_en_s = 1'b1;
            ram_we_s = req_we ? mask8_s[3:0] : 4'b0000;
        end else begin
            ram_en_s = 1'b0;
        end
    end

    dmem_ram #(
        .AW        (WA_W),
        .INIT_ZERO (INIT_ZERO)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en_s),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    // Control FSM; accepting a request captures everything the later beat and response need.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            mode_r  <= 3'b000;
            lane_r  <= 2'b00;
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            split_r <= 1'b0;
            be1_r   <= 4'b0000;
            wd1_r   <= 32'h0000_0000;
            lo_r    <= 32'h0000_0000;
            idx1_r  <= '0;
        end else if (acc_s) begin
            mode_r  <= req_mode;
            lane_r  <= lane_s;
            we_r    <= req_we;
            err_r   <= err_s;
            split_r <= cross_s && !err_s;
            be1_r   <= mask8_s[7:4];
            wd1_r   <= wide_s[63:32];
            idx1_r  <= idx_s + {{(WA_W-1){1'b0}}, 1'b1};
            state_r <= (cross_s && !err_s) ? ST_BEAT2 : ST_RESP;
        end else begin
            case (state_r)
                ST_BEAT2: begin
                    lo_r    <= ram_rdata_s;
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Load merge: concatenate both beats, drop the leading lanes, then extend per mode.
    always_comb begin
        merged_s = split_r ? {ram_rdata_s, lo_r} : {32'h0000_0000, ram_rdata_s};
        sel_s    = 32'(merged_s >> {lane_r, 3'b000});
        case (mode_r)
            MODE_B:  ext_s = {{24{sel_s[7]}}, sel_s[7:0]};
            MODE_H:  ext_s = {{16{sel_s[15]}}, sel_s[15:0]};
            MODE_W:  ext_s = sel_s;
            MODE_BU: ext_s = {24'h00_0000, sel_s[7:0]};
            MODE_HU: ext_s = {16'h0000, sel_s[15:0]};
            default: ext_s = 32'h0000_0000;
        endcase
    end

    assign rsp_valid = (state_r == ST_RESP);
    assign rsp_err   = rsp_valid && err_r;
    assign rsp_rdata = (rsp_valid && !err_r && !we_r) ? ext_s : 32'h0000_0000;

endmodule
